// File: rtl/rtc_timekeeper.sv
// Real-time timekeeper: prescaled seconds counter with HH:MM:SS registers,
// validated time load, 12/24-hour display conversion and a sticky one-shot alarm.
module rtc_timekeeper #(
    parameter int PRESCALE = 65536,
    parameter int PRE_W    = 16
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       run,
    input  logic       set_en,
    input  logic [4:0] set_hour,
    input  logic [5:0] set_minute,
    input  logic [5:0] set_second,
    input  logic       mode_12h,
    input  logic       alarm_en,
    input  logic [4:0] alarm_hour,
    input  logic [5:0] alarm_minute,
    input  logic       alarm_clear,
    output logic [4:0] hour,
    output logic [5:0] minute,
    output logic [5:0] second,
    output logic       pm,
    output logic       second_pulse,
    output logic       set_err,
    output logic       alarm_active
);

    typedef struct packed {
        logic [4:0] hour;
        logic [5:0] minute;
        logic [5:0] second;
    } rtc_time_t;

    logic [PRE_W-1:0] pre;
    rtc_time_t        cur;
    rtc_time_t        inc;
    rtc_time_t        ld;
    logic             tick;
    logic             set_ok;
    logic             load;
    logic             match;

    assign tick   = run && (pre == PRE_W'(PRESCALE - 1));
    assign set_ok = (set_hour <= 5'd23) && (set_minute <= 6'd59) && (set_second <= 6'd59);
    assign load   = set_en && set_ok;
    assign ld     = '{hour: set_hour, minute: set_minute, second: set_second};

    // Ripple-carry increment so 23:59:59 -> 00:00:00 completes in one edge.
    always_comb begin
        inc = cur;
        if (cur.second == 6'd59) begin
            inc.second = '0;
            if (cur.minute == 6'd59) begin
                inc.minute = '0;
                inc.hour   = (cur.hour == 5'd23) ? 5'd0 : cur.hour + 5'd1;
            end else begin
                inc.minute = cur.minute + 6'd1;
            end
        end else begin
            inc.second = cur.second + 6'd1;
        end
    end

    // Only a tick-driven update can fire the alarm; loads never do.
    assign match = alarm_en && tick && !load &&
                   (inc.hour == alarm_hour) && (inc.minute == alarm_minute) &&
                   (inc.second == 6'd0);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pre          <= '0;
            cur          <= '0;
            second_pulse <= 1'b0;
            set_err      <= 1'b0;
            alarm_active <= 1'b0;
        end else begin
            second_pulse <= 1'b0;
            set_err      <= set_en && !set_ok;
            if (load) begin
                cur <= ld;
                pre <= '0;
            end else if (tick) begin
                cur          <= inc;
                pre          <= '0;
                second_pulse <= 1'b1;
            end else if (run) begin
                pre <= pre + PRE_W'(1);
            end
            if (match)
                alarm_active <= 1'b1;
            else if (alarm_clear || !alarm_en)
                alarm_active <= 1'b0;
        end
    end

    always_comb begin
        hour = cur.hour;
        if (mode_12h) begin
            if (cur.hour == 5'd0)
                hour = 5'd12;
            else if (cur.hour > 5'd12)
                hour = cur.hour - 5'd12;
        end
    end

    assign pm     = (cur.hour >= 5'd12);
    assign minute = cur.minute;
    assign second = cur.second;

endmodule

// File: doc/rtc_timekeeper.md
Name: rtc_timekeeper

Overview:
Parametrised real-time timekeeper that generates hours, minutes and seconds from the system clock through a configurable prescaler. It adds run/stop control, a validated synchronous time load, 12/24-hour display modes and a one-shot alarm with a sticky flag. It sits between the system clock and the segment display driver, and feeds {hour, minute} or {minute, second} to the display mux.

Parameters:
PRESCALE, 65536, system clock cycles per second; legal range 2..2^24.
PRE_W, 16, prescaler counter width; must satisfy 2^PRE_W >= PRESCALE.

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low
run  input  1  1 = time advances; 0 = prescaler and time frozen
set_en  input  1  one-cycle strobe: load set_* into the time registers
set_hour  input  5  load value, 0..23 (24-h encoding)
set_minute  input  6  load value, 0..59
set_second  input  6  load value, 0..59
mode_12h  input  1  0 = 24-h display, 1 = 12-h display
alarm_en  input  1  alarm armed
alarm_hour  input  5  alarm hour, 0..23
alarm_minute  input  6  alarm minute, 0..59
alarm_clear  input  1  clears alarm_active
hour  output  5  displayed hour: 0..23 when mode_12h=0, 1..12 when mode_12h=1
minute  output  6  0..59
second  output  6  0..59
pm  output  1  1 when internal hour >= 12, valid in both modes
second_pulse  output  1  one-cycle pulse on every second rollover
set_err  output  1  one-cycle pulse when a load is rejected
alarm_active  output  1  sticky alarm flag

Behaviour:
- Reset (async assert, sync release): prescaler=0, internal hour/minute/second=0, second_pulse=0, set_err=0, alarm_active=0. The hour output reads 0 in 24-h mode and 12 in 12-h mode; pm=0.
- Prescaler: counts 0..PRESCALE-1 while run=1. tick = run && (pre == PRESCALE-1). On tick, pre wraps to 0. When run=0, pre holds its value; there is no partial-second loss.
- On the clock edge where tick=1:
  - second increments; 59 wraps to 0 and carries.
  - On carry, minute increments; 59 wraps to 0 and carries.
  - On carry, hour increments; 23 wraps to 0.
  - second_pulse=1 for exactly the cycle in which the new time is visible.
  - Full rollover 23:59:59 -> 00:00:00 happens in a single edge.
- Time load: when set_en=1 and all values are legal (hour<=23, minute<=59, second<=59), the values are loaded on that edge and pre is cleared to 0.
  - Load has priority over a simultaneous tick. In that case no second_pulse is raised and the tick is discarded.
  - Load works regardless of run.
  - If any value is illegal, nothing changes (time and pre keep their normal behaviour, including a coincident tick) and set_err pulses for 1 cycle.
- Display conversion is combinational from the internal hour:
  - 24-h mode: hour = internal hour.
  - 12-h mode: internal 0 -> 12; 1..12 -> same; 13..23 -> internal-12.
  - pm = (internal >= 12).
  - mode_12h may change at any time and only affects the outputs.
- Alarm:
  - Match = alarm_en && tick-driven update produces internal hour==alarm_hour, minute==alarm_minute, second==0.
  - A match sets alarm_active on that edge.
  - A load never triggers the alarm, even if the loaded value matches.
  - alarm_active clears when alarm_clear=1 or alarm_en=0.
  - If a match coincides with alarm_clear=1, set wins.
  - alarm_en=0 blocks setting.
- Latency: all outputs except hour/pm conversion are registered; a time change is visible 1 cycle after the causing edge's inputs.

Test Plan:
- PRESCALE=4, run=1 from reset -> second_pulse every 4th cycle. After 12 cycles: second=3, minute=0, hour=0. Pulses are 1 cycle wide.
- Load 23:59:59, run=1 -> after 4 cycles: 00:00:00 with one second_pulse. In 12-h mode, hour=12 and pm=0. Before the wrap, hour=11 and pm=1.
- run toggled 0 for 10 cycles at pre=2 -> time and pre frozen. After run=1, the next tick arrives 2 cycles later. Zero ticks occur while stopped.
- set_en with hour=24 (or minute=60) -> time unchanged, set_err pulses 1 cycle. set_en coinciding with tick with legal 05:06:07 -> exactly 05:06:07, no second_pulse.
- Alarm 07:30, load 07:29:58, alarm_en=1 -> alarm_active rises on the edge where 07:30:00 appears and stays high. alarm_clear clears it. Loading 07:30:00 directly leaves it 0.
- Reset asserted mid-count at 12:34:56 with alarm_active=1 -> all outputs reset immediately (asynchronously). After release, counting restarts from 00:00:00 with a full PRESCALE period.
